// File: rtl/framebuffer_scanout.sv
// On-chip framebuffer with a clear controller, scanned out as a centred VGA raster.
// The raster reads the RAM through a two-stage pipeline that also carries sync and DE.
module framebuffer_scanout #(
  parameter int WIDTH_BITS  = 8,
  parameter int HEIGHT_BITS = 8,
  parameter int H_VISIBLE   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_VISIBLE   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int X_OFFSET    = 192,
  parameter int Y_OFFSET    = 112,
  parameter int PIX_DIV     = 2
) (
  input  logic                   clock,
  input  logic                   not_reset,
  input  logic [WIDTH_BITS-1:0]  iX,
  input  logic [HEIGHT_BITS-1:0] iY,
  input  logic [2:0]             iR,
  input  logic [2:0]             iG,
  input  logic [2:0]             iB,
  input  logic                   iWren,
  input  logic                   iClear,
  output logic                   oClearBusy,
  output logic                   oHsync,
  output logic                   oVsync,
  output logic                   oDe,
  output logic [2:0]             oR,
  output logic [2:0]             oG,
  output logic [2:0]             oB,
  output logic                   oFrameStart
);
  localparam int WIDTH   = 2**WIDTH_BITS;
  localparam int HEIGHT  = 2**HEIGHT_BITS;
  localparam int DEPTH   = WIDTH * HEIGHT;
  localparam int A_W     = WIDTH_BITS + HEIGHT_BITS;
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int H_W     = $clog2(H_TOTAL);
  localparam int V_W     = $clog2(V_TOTAL);
  localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
  localparam logic [H_W-1:0]   H_LAST   = H_W'(H_TOTAL - 1);
  localparam logic [V_W-1:0]   V_LAST   = V_W'(V_TOTAL - 1);
  localparam logic [H_W-1:0]   H_VIS_L  = H_W'(H_VISIBLE);
  localparam logic [V_W-1:0]   V_VIS_L  = V_W'(V_VISIBLE);
  localparam logic [H_W-1:0]   HS_BEG   = H_W'(H_VISIBLE + H_FRONT);
  localparam logic [H_W-1:0]   HS_END   = H_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [V_W-1:0]   VS_BEG   = V_W'(V_VISIBLE + V_FRONT);
  localparam logic [V_W-1:0]   VS_END   = V_W'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic signed [H_W:0] X_OFF_S = (H_W+1)'(X_OFFSET);
  localparam logic signed [V_W:0] Y_OFF_S = (V_W+1)'(Y_OFFSET);
  localparam logic signed [H_W:0] WIDTH_S  = (H_W+1)'(WIDTH);
  localparam logic signed [V_W:0] HEIGHT_S = (V_W+1)'(HEIGHT);

  typedef enum logic {S_CLEAR = 1'b0, S_IDLE = 1'b1} state_t;

  state_t           r_state, w_state_nxt;
  logic [A_W-1:0]   r_clr_addr, w_clr_addr_nxt;
  logic             r_busy;
  logic             w_we;
  logic [A_W-1:0]   w_wr_addr;
  logic [8:0]       w_wr_data;

  logic [DIV_W-1:0] r_div;
  logic             w_pix_en;
  logic [H_W-1:0]   r_h_p0;
  logic [V_W-1:0]   r_v_p0;
  logic signed [H_W:0] w_hx_p0;
  logic signed [V_W:0] w_vy_p0;
  logic             w_vis_p0, w_img_p0, w_hs_p0, w_vs_p0, w_first_p0;
  logic [A_W-1:0]   w_rd_addr_p0;

  logic [8:0]       r_mem [DEPTH];
  logic [8:0]       r_rd_p1;
  logic             r_vis_p1, r_img_p1, r_hs_p1, r_vs_p1, r_first_p1;

  logic             r_de_p2, r_hs_p2, r_vs_p2, r_fs_p2;
  logic [8:0]       r_rgb_p2;

  // Controller: CLEAR owns the write port until the last address is zeroed.
  always_ff @(posedge clock or negedge not_reset) begin
    if (!not_reset) begin
      r_state    <= S_CLEAR;
      r_clr_addr <= '0;
      r_busy     <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_clr_addr <= w_clr_addr_nxt;
      r_busy     <= (w_state_nxt == S_CLEAR);
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_clr_addr_nxt = r_clr_addr;
    w_we           = 1'b0;
    w_wr_addr      = '0;
    w_wr_data      = '0;
    case (r_state)
      S_CLEAR: begin
        w_we           = 1'b1;
        w_wr_addr      = r_clr_addr;
        w_clr_addr_nxt = r_clr_addr + 1'b1;
        if (&r_clr_addr) w_state_nxt = S_IDLE;
      end
      S_IDLE: begin
        w_we           = iWren;
        w_wr_addr      = {iY, iX};
        w_wr_data      = {iR, iG, iB};
        w_clr_addr_nxt = '0;
        if (iClear) w_state_nxt = S_CLEAR;
      end
      default: w_state_nxt = S_CLEAR;
    endcase
  end

  // Stage 0: pixel divider and raster counters
  assign w_pix_en = (r_div == DIV_LAST);

  always_ff @(posedge clock or negedge not_reset) begin
    if (!not_reset) begin
      r_div  <= '0;
      r_h_p0 <= '0;
      r_v_p0 <= '0;
    end else begin
      r_div <= w_pix_en ? '0 : r_div + 1'b1;
      if (w_pix_en) begin
        if (r_h_p0 == H_LAST) begin
          r_h_p0 <= '0;
          r_v_p0 <= (r_v_p0 == V_LAST) ? '0 : r_v_p0 + 1'b1;
        end else begin
          r_h_p0 <= r_h_p0 + 1'b1;
        end
      end
    end
  end

  assign w_hx_p0      = $signed({1'b0, r_h_p0}) - X_OFF_S;
  assign w_vy_p0      = $signed({1'b0, r_v_p0}) - Y_OFF_S;
  assign w_vis_p0     = (r_h_p0 < H_VIS_L) && (r_v_p0 < V_VIS_L);
  assign w_img_p0     = w_vis_p0 && !w_hx_p0[H_W] && (w_hx_p0 < WIDTH_S)
                                 && !w_vy_p0[V_W] && (w_vy_p0 < HEIGHT_S);
  assign w_hs_p0      = !((r_h_p0 >= HS_BEG) && (r_h_p0 < HS_END));
  assign w_vs_p0      = !((r_v_p0 >= VS_BEG) && (r_v_p0 < VS_END));
  assign w_first_p0   = (r_h_p0 == '0) && (r_v_p0 == '0);
  assign w_rd_addr_p0 = {w_vy_p0[HEIGHT_BITS-1:0], w_hx_p0[WIDTH_BITS-1:0]};

  // Stage 1: RAM read; a same-clock write to the read address yields the old word
  always_ff @(posedge clock) begin
    if (w_we) r_mem[w_wr_addr] <= w_wr_data;
    if (w_pix_en) r_rd_p1 <= r_mem[w_rd_addr_p0];
  end

  always_ff @(posedge clock or negedge not_reset) begin
    if (!not_reset) begin
      r_vis_p1   <= 1'b0;
      r_img_p1   <= 1'b0;
      r_hs_p1    <= 1'b1;
      r_vs_p1    <= 1'b1;
      r_first_p1 <= 1'b0;
    end else if (w_pix_en) begin
      r_vis_p1   <= w_vis_p0;
      r_img_p1   <= w_img_p0;
      r_hs_p1    <= w_hs_p0;
      r_vs_p1    <= w_vs_p0;
      r_first_p1 <= w_first_p0;
    end
  end

  // Stage 2: output registers
  always_ff @(posedge clock or negedge not_reset) begin
    if (!not_reset) begin
      r_de_p2  <= 1'b0;
      r_hs_p2  <= 1'b1;
      r_vs_p2  <= 1'b1;
      r_rgb_p2 <= '0;
      r_fs_p2  <= 1'b0;
    end else begin
      if (w_pix_en) begin
        r_de_p2  <= r_vis_p1;
        r_hs_p2  <= r_hs_p1;
        r_vs_p2  <= r_vs_p1;
        r_rgb_p2 <= r_img_p1 ? r_rd_p1 : '0;
      end
      r_fs_p2 <= w_pix_en && r_first_p1;
    end
  end

  assign oClearBusy  = r_busy;
  assign oHsync      = r_hs_p2;
  assign oVsync      = r_vs_p2;
  assign oDe         = r_de_p2;
  assign oR          = r_rgb_p2[8:6];
  assign oG          = r_rgb_p2[5:3];
  assign oB          = r_rgb_p2[2:0];
  assign oFrameStart = r_fs_p2;
endmodule

// File: tb/tb_framebuffer_scanout.sv
// Bench for framebuffer_scanout on a reduced raster; a spec-level model predicts each
// raster position when it is scanned and the scoreboard compares it when it reaches the pins.
module tb_framebuffer_scanout;
  localparam int WB = 3, HB = 3, W = 8, H = 8, N = W * H;
  localparam int HV = 40, HF = 4, HS = 6, HBK = 6, HT = HV + HF + HS + HBK;
  localparam int VV = 20, VF = 2, VS = 2, VBK = 3, VT = VV + VF + VS + VBK;
  localparam int XO = 16, YO = 6, PD = 2;
  localparam int FRAME = VT * HT * PD;

  logic clock = 1'b0;
  logic not_reset;
  logic [WB-1:0] iX;
  logic [HB-1:0] iY;
  logic [2:0] iR, iG, iB;
  logic iWren, iClear;
  logic oClearBusy, oHsync, oVsync, oDe, oFrameStart;
  logic [2:0] oR, oG, oB;

  framebuffer_scanout #(
    .WIDTH_BITS(WB), .HEIGHT_BITS(HB),
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HBK),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VBK),
    .X_OFFSET(XO), .Y_OFFSET(YO), .PIX_DIV(PD)
  ) dut (
    .clock(clock), .not_reset(not_reset),
    .iX(iX), .iY(iY), .iR(iR), .iG(iG), .iB(iB),
    .iWren(iWren), .iClear(iClear),
    .oClearBusy(oClearBusy), .oHsync(oHsync), .oVsync(oVsync), .oDe(oDe),
    .oR(oR), .oG(oG), .oB(oB), .oFrameStart(oFrameStart)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [15:0] h;
    logic [15:0] v;
    logic        first;
    logic        de;
    logic        hs;
    logic        vs;
    logic        img;
    logic        known;
    logic [8:0]  rgb;
  } exp_t;

  int n_asserts = 0;
  int n_fail = 0;
  int cyc = 0;
  int mode = 0;

  int   m_div, m_h, m_v, m_addr;
  logic m_clear, m_fs;
  logic [8:0] m_mem [N];
  logic       m_known [N];
  exp_t q[$];
  exp_t m_out;

  int   hs_fall, vs_fall, fs_last;
  logic prev_hs, prev_vs;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_asserts++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp_v);
    end
  endtask

  function automatic exp_t pix(input int h, input int v);
    exp_t e;
    int hx, vy;
    hx = h - XO;
    vy = v - YO;
    e.h     = 16'(h);
    e.v     = 16'(v);
    e.first = (h == 0 && v == 0);
    e.de    = (h < HV && v < VV);
    e.hs    = !(h >= HV + HF && h < HV + HF + HS);
    e.vs    = !(v >= VV + VF && v < VV + VF + VS);
    e.img   = e.de && hx >= 0 && hx < W && vy >= 0 && vy < H;
    e.known = 1'b1;
    e.rgb   = '0;
    if (e.img) begin
      e.known = m_known[vy * W + hx];
      e.rgb   = m_mem[vy * W + hx];
    end
    return e;
  endfunction

  task automatic model_reset();
    exp_t e;
    e = '0;
    e.h = '1;
    e.v = '1;
    e.hs = 1'b1;
    e.vs = 1'b1;
    e.known = 1'b1;
    m_div = 0; m_h = 0; m_v = 0; m_addr = 0;
    m_clear = 1'b1; m_fs = 1'b0;
    q.delete();
    q.push_back(e);
    m_out = e;
    hs_fall = -1; vs_fall = -1; fs_last = -1;
    prev_hs = 1'b1; prev_vs = 1'b1;
  endtask

  task automatic tick();
    logic raster;
    logic [13:0] obs, exp_v, msk;
    raster = 1'b0;
    if (not_reset) begin
      raster = (m_div == PD - 1);
      m_fs = 1'b0;
      if (raster) begin
        q.push_back(pix(m_h, m_v));
        m_out = q.pop_front();
        m_fs = m_out.first;
        if (m_h == HT - 1) begin
          m_h = 0;
          m_v = (m_v == VT - 1) ? 0 : m_v + 1;
        end else begin
          m_h++;
        end
        m_div = 0;
      end else begin
        m_div++;
      end
      if (m_clear) begin
        m_mem[m_addr] = '0;
        m_known[m_addr] = 1'b1;
        if (m_addr == N - 1) m_clear = 1'b0;
        else m_addr++;
      end else begin
        if (iWren) begin
          m_mem[{iY, iX}] = {iR, iG, iB};
          m_known[{iY, iX}] = 1'b1;
        end
        if (iClear) begin
          m_clear = 1'b1;
          m_addr = 0;
        end
      end
    end
    @(posedge clock);
    #1;
    cyc++;
    obs = {oClearBusy, oDe, oHsync, oVsync, oFrameStart, oR, oG, oB};
    if (!not_reset) begin
      exp_v = {5'b10110, 9'd0};
      msk = '1;
    end else begin
      exp_v = {m_clear, m_out.de, m_out.hs, m_out.vs, m_fs, m_out.rgb};
      msk = {5'h1F, {9{m_out.known}}};
    end
    chk("out", 32'(obs & msk), 32'(exp_v & msk));
    if (not_reset) begin
      if (prev_hs && !oHsync) begin
        if (hs_fall >= 0) chk("h_period", cyc - hs_fall, HT * PD);
        hs_fall = cyc;
      end
      if (!prev_hs && oHsync && hs_fall >= 0) chk("h_low", cyc - hs_fall, HS * PD);
      prev_hs = oHsync;
      if (prev_vs && !oVsync) begin
        if (vs_fall >= 0) chk("v_period", cyc - vs_fall, FRAME);
        vs_fall = cyc;
      end
      if (!prev_vs && oVsync && vs_fall >= 0) chk("v_low", cyc - vs_fall, VS * HT * PD);
      prev_vs = oVsync;
      if (oFrameStart) begin
        if (fs_last >= 0) chk("fs_period", cyc - fs_last, FRAME);
        fs_last = cyc;
      end
      if (raster) begin
        if (m_out.v == 16'd2 && m_out.h == 16'd2) chk("vis_bg", {oDe, oR, oG, oB}, {1'b1, 9'd0});
        if (m_out.v == 16'd2 && m_out.h == 16'd45) chk("hblank", {oDe, oR, oG, oB}, 10'd0);
        if (mode == 1 && m_out.v == 16'(YO + 3)) begin
          if (m_out.h == 16'(XO + 5)) chk("px_hit", {oDe, oR, oG, oB}, {1'b1, 9'o707});
          if (m_out.h == 16'(XO + 4) || m_out.h == 16'(XO + 6)) chk("px_nbr", {oR, oG, oB}, 9'd0);
        end
        if (mode == 2 && m_out.h == 16'(XO) && m_out.v == 16'(YO))
          chk("early_wr", {oR, oG, oB}, 9'd0);
        if (mode == 3 && m_out.img) chk("cleared", {oR, oG, oB}, 9'd0);
      end
    end
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic wr(input int x, input int y, input int r, input int g, input int b);
    iX = WB'(x); iY = HB'(y);
    iR = 3'(r); iG = 3'(g); iB = 3'(b);
    iWren = 1'b1;
    tick();
    iWren = 1'b0;
  endtask

  task automatic wait_clear(input int second_at, output int n);
    n = 0;
    while (oClearBusy && n < N + 20) begin
      if (n == second_at) iClear = 1'b1;
      tick();
      iClear = 1'b0;
      n++;
    end
  endtask

  task automatic do_reset();
    not_reset = 1'b0;
    #1;
    chk("rst_async", {oClearBusy, oDe, oHsync, oVsync, oFrameStart, oR, oG, oB}, {5'b10110, 9'd0});
    model_reset();
    tick();
    not_reset = 1'b1;
  endtask

  initial begin
    int n;
    not_reset = 1'b0;
    iX = '0; iY = '0; iR = '0; iG = '0; iB = '0;
    iWren = 1'b0; iClear = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_mem[i] = '0;
      m_known[i] = 1'b0;
    end
    model_reset();
    run(3);
    not_reset = 1'b1;
    wait_clear(-1, n);
    chk("clr_len", n, N);

    wr(5, 3, 7, 0, 7);
    run(8);
    mode = 1;
    run(3 * FRAME);
    mode = 0;

    do_reset();
    run(10);
    chk("busy_early", oClearBusy, 1);
    wr(0, 0, 7, 7, 7);
    wait_clear(-1, n);
    chk("clr_rest", n, N - 11);
    run(8);
    mode = 2;
    run(FRAME + 20);
    mode = 0;

    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        wr(x, y, 7, 7, 7);
    run(FRAME / 2);
    iClear = 1'b1;
    tick();
    iClear = 1'b0;
    chk("busy_start", oClearBusy, 1);
    wait_clear(10, n);
    chk("clr_len2", n, N);
    n = 0;
    while (!oFrameStart && n < 2 * FRAME) begin
      tick();
      n++;
    end
    chk("fs_seen", oFrameStart, 1);
    mode = 3;
    run(FRAME + 20);
    mode = 0;

    do_reset();
    run(20);
    do_reset();
    wait_clear(-1, n);
    chk("clr_restart", n, N);
    run(200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
